// File: rtl/ahb_pkg.sv
// Shared AHB-Lite encodings for the memory-backed subordinate.
// Transfer/burst/size/response codes, slave FSM states, byte-lane helpers.
package ahb_pkg;

    typedef enum logic [1:0] {
        TR_IDLE   = 2'b00,
        TR_BUSY   = 2'b01,
        TR_NONSEQ = 2'b10,
        TR_SEQ    = 2'b11
    } htrans_t;

    typedef enum logic [2:0] {
        BU_SINGLE = 3'b000,
        BU_INCR   = 3'b001,
        BU_INCR4  = 3'b011,
        BU_INCR8  = 3'b101,
        BU_INCR16 = 3'b111
    } hburst_t;

    localparam logic [2:0] SZ_BYTE = 3'b000;
    localparam logic [2:0] SZ_HALF = 3'b001;
    localparam logic [2:0] SZ_WORD = 3'b010;

    localparam logic RSP_OKAY  = 1'b0;
    localparam logic RSP_ERROR = 1'b1;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_WAIT,
        ST_ERR1,
        ST_ERR2
    } slv_state_t;

    function automatic logic [3:0] lane_mask(
        input logic [2:0] size,
        input logic [1:0] lo
    );
        case (size)
            SZ_BYTE: lane_mask = 4'b0001 << lo;
            SZ_HALF: lane_mask = lo[1] ? 4'b1100 : 4'b0011;
            SZ_WORD: lane_mask = 4'b1111;
            default: lane_mask = 4'b0000;
        endcase
    endfunction

    // Bit i is 1 when byte i plus its check bit has odd parity.
    function automatic logic [3:0] lane_odd(
        input logic [31:0] d,
        input logic [3:0]  c
    );
        for (int i = 0; i < 4; i++)
            lane_odd[i] = ^{c[i], d[8*i +: 8]};
    endfunction

endpackage

// File: rtl/ahb_slave_if.sv
// AHB-Lite subordinate-side bus bundle.
// Master modport drives address/data phase, slave modport answers.
interface ahb_slave_if #(
    parameter int ADDR_WIDTH = 20,
    parameter int DATA_WIDTH = 32
);
    logic                  HSEL;
    logic [ADDR_WIDTH-1:0] HADDR;
    logic [1:0]            HTRANS;
    logic                  HWRITE;
    logic [2:0]            HSIZE;
    logic [2:0]            HBURST;
    logic [DATA_WIDTH-1:0] HWDATA;
    logic [3:0]            HWDATACHK;
    logic                  HREADY;
    logic [DATA_WIDTH-1:0] HRDATA;
    logic                  HREADYOUT;
    logic                  HRSP;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST,
        output HWDATA, HWDATACHK, HREADY,
        input  HRDATA, HREADYOUT, HRSP
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HBURST,
        input  HWDATA, HWDATACHK, HREADY,
        output HRDATA, HREADYOUT, HRSP
    );
endinterface

// File: rtl/ahb_byte_ram.sv
// Word-organised RAM with per-byte write enables.
// Read port is combinational on the same index used for writes.
module ahb_byte_ram #(
    parameter int MEM_DEPTH = 1024,
    parameter int IW        = $clog2(MEM_DEPTH)
) (
    input  logic          i_clk,
    input  logic [IW-1:0] i_idx,
    input  logic [3:0]    i_we,
    input  logic [31:0]   i_wdata,
    output logic [31:0]   o_rdata
);
    logic [31:0] r_mem [MEM_DEPTH];

    always_ff @(posedge i_clk) begin
        for (int i = 0; i < 4; i++) begin
            if (i_we[i])
                r_mem[i_idx][8*i +: 8] <= i_wdata[8*i +: 8];
        end
    end

    assign o_rdata = r_mem[i_idx];
endmodule

// File: rtl/ahb_slave.sv
// AHB-Lite memory-backed subordinate with wait states, ERROR
// responses and write-data parity checking.
module ahb_slave
    import ahb_pkg::*;
#(
    parameter int ADDR_WIDTH  = 20,
    parameter int DATA_WIDTH  = 32,
    parameter int MEM_DEPTH   = 1024,
    parameter int WAIT_STATES = 0
) (
    input  logic       HCLK,
    input  logic       HRESET,
    ahb_slave_if.slave bus,
    output logic       parity_err
);
    localparam int IW = $clog2(MEM_DEPTH);
    localparam logic [3:0] WS_LAST = 4'(WAIT_STATES - 1);

    logic                  w_acc;
    logic                  w_err;
    logic                  w_upd;
    logic                  w_rdy;
    logic                  w_rsp;
    logic                  w_good;
    logic                  w_commit;
    logic [31:0]           w_widx;
    logic [3:0]            w_en;
    logic [3:0]            w_we;
    logic [DATA_WIDTH-1:0] w_rdata;
    slv_state_t            w_next;

    slv_state_t r_state;
    logic [3:0] r_cnt;
    logic       r_act;
    logic       r_write;
    logic [2:0] r_size;
    logic [1:0] r_lo;
    logic [IW-1:0] r_idx;
    logic       r_perr;

    assign w_acc  = bus.HSEL & bus.HTRANS[1] & bus.HREADY;
    assign w_widx = 32'(bus.HADDR[ADDR_WIDTH-1:2]);
    assign w_err  = (bus.HSIZE > SZ_WORD)
                  | ((bus.HSIZE == SZ_HALF) & bus.HADDR[0])
                  | ((bus.HSIZE == SZ_WORD) & (bus.HADDR[1:0] != 2'b00))
                  | (w_widx >= 32'(MEM_DEPTH));
    // Control only advances when our own data phase is not stalling.
    assign w_upd  = bus.HREADY & w_rdy;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_act   <= 1'b0;
            r_write <= 1'b0;
            r_size  <= SZ_BYTE;
            r_lo    <= 2'b00;
            r_idx   <= '0;
        end else if (w_upd) begin
            r_act   <= w_acc & ~w_err;
            r_write <= bus.HWRITE;
            r_size  <= bus.HSIZE;
            r_lo    <= bus.HADDR[1:0];
            r_idx   <= bus.HADDR[IW+1:2];
        end
    end

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET) begin
            r_state <= ST_IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_next;
            r_cnt   <= (r_state == ST_WAIT) ? r_cnt + 4'd1 : 4'd0;
        end
    end

    always_comb begin
        w_next = r_state;
        unique case (r_state)
            ST_IDLE, ST_ERR2: begin
                w_next = ST_IDLE;
                if (w_acc && w_err)
                    w_next = ST_ERR1;
                else if (w_acc && WAIT_STATES > 0)
                    w_next = ST_WAIT;
            end
            ST_WAIT: if (r_cnt == WS_LAST) w_next = ST_IDLE;
            ST_ERR1: w_next = ST_ERR2;
            default: w_next = ST_IDLE;
        endcase
    end

    always_comb begin
        w_rdy = 1'b1;
        w_rsp = RSP_OKAY;
        unique case (r_state)
            ST_WAIT: w_rdy = 1'b0;
            ST_ERR1: begin
                w_rdy = 1'b0;
                w_rsp = RSP_ERROR;
            end
            ST_ERR2: w_rsp = RSP_ERROR;
            default: ;
        endcase
    end

    assign w_en     = lane_mask(r_size, r_lo);
    assign w_good   = &(lane_odd(bus.HWDATA, bus.HWDATACHK) | ~w_en);
    assign w_commit = r_act & r_write & w_rdy;
    assign w_we     = (w_commit & w_good) ? w_en : 4'b0000;

    always_ff @(posedge HCLK or posedge HRESET) begin
        if (HRESET)
            r_perr <= 1'b0;
        else if (w_commit & ~w_good)
            r_perr <= 1'b1;
    end

    ahb_byte_ram #(
        .MEM_DEPTH (MEM_DEPTH),
        .IW        (IW)
    ) u_ram (
        .i_clk   (HCLK),
        .i_idx   (r_idx),
        .i_we    (w_we),
        .i_wdata (bus.HWDATA),
        .o_rdata (w_rdata)
    );

    assign bus.HRDATA    = (r_act & ~r_write) ? w_rdata : '0;
    assign bus.HREADYOUT = w_rdy;
    assign bus.HRSP      = w_rsp;
    assign parity_err    = r_perr;
endmodule

// File: tb/tb_ahb_slave.sv
// Bench for ahb_slave: zero- and two-wait-state instances driven with
// directed and random transfers, checked against a word-array model.
module tb_ahb_slave;
    import ahb_pkg::*;

    localparam int AW    = 20;
    localparam int DEPTH = 1024;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic          dsel;
    logic          t_sel;
    logic [AW-1:0] t_addr;
    logic [1:0]    t_trans;
    logic          t_write;
    logic [2:0]    t_size;
    logic [2:0]    t_burst;
    logic [31:0]   t_wdata;
    logic [3:0]    t_chk;
    logic          pe0, pe2;

    ahb_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) b0();
    ahb_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(32)) b2();

    assign b0.HSEL      = t_sel & ~dsel;
    assign b0.HADDR     = t_addr;
    assign b0.HTRANS    = t_trans;
    assign b0.HWRITE    = t_write;
    assign b0.HSIZE     = t_size;
    assign b0.HBURST    = t_burst;
    assign b0.HWDATA    = t_wdata;
    assign b0.HWDATACHK = t_chk;
    assign b0.HREADY    = b0.HREADYOUT;

    assign b2.HSEL      = t_sel & dsel;
    assign b2.HADDR     = t_addr;
    assign b2.HTRANS    = t_trans;
    assign b2.HWRITE    = t_write;
    assign b2.HSIZE     = t_size;
    assign b2.HBURST    = t_burst;
    assign b2.HWDATA    = t_wdata;
    assign b2.HWDATACHK = t_chk;
    assign b2.HREADY    = b2.HREADYOUT;

    ahb_slave #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(32),
        .MEM_DEPTH(DEPTH), .WAIT_STATES(0)
    ) u0 (
        .HCLK(clk), .HRESET(rst), .bus(b0), .parity_err(pe0)
    );

    ahb_slave #(
        .ADDR_WIDTH(AW), .DATA_WIDTH(32),
        .MEM_DEPTH(DEPTH), .WAIT_STATES(2)
    ) u2 (
        .HCLK(clk), .HRESET(rst), .bus(b2), .parity_err(pe2)
    );

    logic [31:0] o_rdata;
    logic        o_rdy, o_rsp, o_pe;
    assign o_rdata = dsel ? b2.HRDATA    : b0.HRDATA;
    assign o_rdy   = dsel ? b2.HREADYOUT : b0.HREADYOUT;
    assign o_rsp   = dsel ? b2.HRSP      : b0.HRSP;
    assign o_pe    = dsel ? pe2          : pe0;

    bit [31:0] mdl [0:1][0:DEPTH-1];
    bit        mpe [0:1];

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int ws();
        return dsel ? 2 : 0;
    endfunction

    function automatic logic [3:0] good_chk(input logic [31:0] d);
        logic [3:0] c;
        for (int i = 0; i < 4; i++) c[i] = ~^d[8*i +: 8];
        return c;
    endfunction

    function automatic bit m_err(input logic [2:0] sz, input logic [AW-1:0] a);
        if (sz > 3'd2) return 1'b1;
        if (sz == 3'd1 && a[0]) return 1'b1;
        if (sz == 3'd2 && a[1:0] != 2'b00) return 1'b1;
        return int'(a >> 2) >= DEPTH;
    endfunction

    // Bytes start..start+2^size-1 of the word are written, all or none.
    function automatic void m_write(input logic [AW-1:0] a, input logic [2:0] sz,
                                    input logic [31:0] d, input logic [3:0] c);
        int s, n, idx;
        bit ok;
        s = int'(a[1:0]);
        n = 1 << sz;
        idx = int'(a >> 2);
        ok = 1'b1;
        for (int b = 0; b < 4; b++)
            if (b >= s && b < s + n && (^{c[b], d[8*b +: 8]}) !== 1'b1) ok = 1'b0;
        if (!ok) begin
            mpe[int'(dsel)] = 1'b1;
            return;
        end
        for (int b = 0; b < 4; b++)
            if (b >= s && b < s + n) mdl[int'(dsel)][idx][8*b +: 8] = d[8*b +: 8];
    endfunction

    task automatic xfer(input bit wr, input logic [2:0] sz, input logic [AW-1:0] a,
                        input logic [31:0] d, input logic [3:0] flip, input string tag);
        bit e;
        logic [31:0] exp_rd;
        e = m_err(sz, a);
        t_sel = 1'b1; t_trans = TR_NONSEQ; t_addr = a;
        t_write = wr; t_size = sz; t_burst = BU_SINGLE;
        @(posedge clk); #1;
        t_sel = 1'b0; t_trans = TR_IDLE;
        t_wdata = d; t_chk = good_chk(d) ^ flip;
        if (e) begin
            @(negedge clk);
            chk({tag, ":err1_rdy"}, o_rdy, 1'b0);
            chk({tag, ":err1_rsp"}, o_rsp, 1'b1);
            chk({tag, ":err1_rd"}, o_rdata, 32'h0);
            @(posedge clk); #1;
            @(negedge clk);
            chk({tag, ":err2_rdy"}, o_rdy, 1'b1);
            chk({tag, ":err2_rsp"}, o_rsp, 1'b1);
            @(posedge clk); #1;
        end else begin
            exp_rd = wr ? 32'h0 : mdl[int'(dsel)][int'(a >> 2)];
            for (int k = 0; k < ws(); k++) begin
                @(negedge clk);
                chk({tag, ":wait_rdy"}, o_rdy, 1'b0);
                chk({tag, ":wait_rsp"}, o_rsp, 1'b0);
                @(posedge clk); #1;
            end
            @(negedge clk);
            chk({tag, ":rdy"}, o_rdy, 1'b1);
            chk({tag, ":rsp"}, o_rsp, 1'b0);
            chk({tag, ":rdata"}, o_rdata, exp_rd);
            @(posedge clk); #1;
            if (wr) m_write(a, sz, d, t_chk);
        end
        chk({tag, ":perr"}, o_pe, mpe[int'(dsel)]);
    endtask

    task automatic burst4(input logic [AW-1:0] base, input logic [31:0] seed);
        int beat, waits, budget;
        logic [31:0] d [4];
        for (int i = 0; i < 4; i++) d[i] = seed + 32'(i) * 32'h01010101;
        t_sel = 1'b1; t_trans = TR_NONSEQ; t_write = 1'b1;
        t_size = SZ_WORD; t_burst = BU_INCR4; t_addr = base;
        @(posedge clk); #1;
        beat = 0; waits = 0; budget = 0;
        while (beat < 4 && budget < 40) begin
            t_wdata = d[beat];
            t_chk = good_chk(d[beat]);
            if (beat < 3) begin
                t_trans = TR_SEQ;
                t_addr = base + AW'(4 * (beat + 1));
            end else begin
                t_sel = 1'b0;
                t_trans = TR_IDLE;
            end
            @(negedge clk);
            budget++;
            if (o_rdy) begin
                chk("burst_waits", 32'(waits), 32'(ws()));
                m_write(base + AW'(4 * beat), SZ_WORD, d[beat], t_chk);
                beat++;
                waits = 0;
            end else begin
                waits++;
            end
            @(posedge clk); #1;
        end
        chk("burst_done", 32'(beat), 32'd4);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [AW-1:0] a;
        logic [2:0]    sz;
        int            r;

        dsel = 1'b0; t_sel = 1'b0; t_trans = TR_IDLE; t_addr = '0;
        t_write = 1'b0; t_size = SZ_BYTE; t_burst = BU_SINGLE;
        t_wdata = '0; t_chk = '0;
        mpe[0] = 1'b0; mpe[1] = 1'b0;
        rst = 1'b1;
        #12;
        for (int s = 0; s < 2; s++) begin
            dsel = s[0];
            #1;
            chk("rst_rdy", o_rdy, 1'b1);
            chk("rst_rsp", o_rsp, 1'b0);
            chk("rst_rd", o_rdata, 32'h0);
            chk("rst_pe", o_pe, 1'b0);
        end
        dsel = 1'b0;
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;

        xfer(1, SZ_WORD, 20'h10, 32'hDEADBEEF, 4'h0, "w_dead");
        xfer(0, SZ_WORD, 20'h10, 32'h0, 4'h0, "r_dead");
        xfer(1, SZ_WORD, 20'h10, 32'h11223344, 4'h0, "w_1122");
        xfer(1, SZ_BYTE, 20'h13, 32'hAA000000, 4'h0, "w_byte");
        xfer(0, SZ_WORD, 20'h10, 32'h0, 4'h0, "r_byte");
        chk("byte_model", mdl[0][4], 32'hAA223344);
        xfer(1, SZ_HALF, 20'h10, 32'h00005566, 4'h0, "w_half");
        xfer(0, SZ_WORD, 20'h10, 32'h0, 4'h0, "r_half");
        chk("half_model", mdl[0][4], 32'hAA225566);

        xfer(1, SZ_WORD, 20'h02, 32'h01020304, 4'h0, "e_misal");
        xfer(1, SZ_WORD, AW'(4 * DEPTH), 32'h05060708, 4'h0, "e_range");
        xfer(1, 3'b011, 20'h10, 32'h090A0B0C, 4'h0, "e_size");
        xfer(0, SZ_WORD, 20'h10, 32'h0, 4'h0, "r_unchg");

        xfer(1, SZ_WORD, 20'h20, 32'h12345678, 4'h0, "w_par_old");
        xfer(1, SZ_WORD, 20'h20, 32'h000000FF, 4'h1, "w_par_bad");
        xfer(0, SZ_WORD, 20'h20, 32'h0, 4'h0, "r_par");
        chk("par_sticky", pe0, 1'b1);

        t_sel = 1'b1; t_trans = TR_NONSEQ; t_write = 1'b1;
        t_size = SZ_WORD; t_addr = 20'h30;
        @(posedge clk); #1;
        t_wdata = 32'h0BADF00D; t_chk = good_chk(32'h0BADF00D);
        t_write = 1'b0;
        @(negedge clk);
        chk("raw_wrdy", o_rdy, 1'b1);
        @(posedge clk); #1;
        m_write(20'h30, SZ_WORD, 32'h0BADF00D, t_chk);
        t_sel = 1'b0; t_trans = TR_IDLE;
        @(negedge clk);
        chk("raw_rdata", o_rdata, mdl[0][12]);
        chk("raw_rrdy", o_rdy, 1'b1);
        @(posedge clk); #1;

        dsel = 1'b1;
        xfer(1, SZ_WORD, 20'h40, 32'hCAFEF00D, 4'h0, "w2_cafe");
        xfer(0, SZ_WORD, 20'h40, 32'h0, 4'h0, "r2_cafe");
        xfer(0, SZ_HALF, 20'h41, 32'h0, 4'h0, "e2_half");

        t_sel = 1'b1; t_trans = TR_NONSEQ; t_write = 1'b1;
        t_size = SZ_WORD; t_addr = 20'h40;
        @(posedge clk); #1;
        t_sel = 1'b0; t_trans = TR_IDLE;
        t_wdata = 32'h55555555; t_chk = good_chk(32'h55555555);
        @(negedge clk);
        chk("rstw_wait", o_rdy, 1'b0);
        #2 rst = 1'b1;
        #1;
        mpe[0] = 1'b0; mpe[1] = 1'b0;
        chk("rstw_rdy", o_rdy, 1'b1);
        chk("rstw_rsp", o_rsp, 1'b0);
        chk("rstw_rd", o_rdata, 32'h0);
        chk("rstw_pe0", pe0, 1'b0);
        @(negedge clk); rst = 1'b0;
        @(posedge clk); #1;
        xfer(0, SZ_WORD, 20'h40, 32'h0, 4'h0, "r2_old");
        chk("rstw_model", mdl[1][16], 32'hCAFEF00D);

        burst4(20'h80, 32'h10203040);
        for (int i = 0; i < 4; i++)
            xfer(0, SZ_WORD, 20'h80 + AW'(4 * i), 32'h0, 4'h0, "r2_burst");

        for (int s = 0; s < 2; s++) begin
            dsel = s[0];
            for (int i = 0; i < 16; i++)
                xfer(1, SZ_WORD, AW'(4 * i), $urandom, 4'h0, "rnd_init");
            for (int n = 0; n < 60; n++) begin
                r = int'($urandom_range(0, 15));
                sz = (r == 0) ? 3'b011 : 3'($urandom_range(0, 2));
                a = (r == 1) ? AW'(4 * DEPTH + int'($urandom_range(0, 63)))
                             : AW'($urandom_range(0, 63));
                xfer($urandom_range(0, 1) == 1, sz, a, $urandom,
                     (r == 2) ? 4'($urandom_range(1, 15)) : 4'h0, "rnd");
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
